// File: rtl/ula_pkg.sv
// Shared types and constants for the 8-bit execute-stage ALU.
// Opcodes 10-15 are reserved and decode to a zero result.
package ula_pkg;

    localparam int DATA_W   = 8;
    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOT = 4'd0,
        OP_AND = 4'd1,
        OP_OR  = 4'd2,
        OP_XOR = 4'd3,
        OP_ADD = 4'd4,
        OP_SUB = 4'd5,
        OP_SLR = 4'd6,
        OP_SRR = 4'd7,
        OP_MUL = 4'd8,
        OP_ROL = 4'd9
    } opcode_t;

    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ula_if.sv
// Operand/opcode bundle into the ALU and registered result/flags out of it.
// Plain wires; no handshake, a new result is produced every cycle.
interface ula_if;
    import ula_pkg::*;

    data_t                 a;
    data_t                 b;
    logic [OPCODE_W-1:0]   select;
    data_t                 s;
    logic                  zero;
    logic                  carry;

    modport master (output a, b, select, input s, zero, carry);
    modport slave  (input a, b, select, output s, zero, carry);

endinterface

// File: rtl/ula_shifter.sv
// Combinational shift/rotate unit: SLR, SRR (zero when b >= 8) and ROL (b mod 8).
// Latency 0; no backpressure. Non-shift opcodes yield zero.
module ula_shifter
    import ula_pkg::*;
(
    input  data_t   a,
    input  data_t   b,
    input  opcode_t op,
    output data_t   res
);

    logic [2:0] amt;
    logic       over_range;

    assign amt        = b[2:0];
    assign over_range = |b[DATA_W-1:3];

    always_comb begin
        res = '0;
        case (op)
            OP_SLR: res = over_range ? '0 : (a << amt);
            OP_SRR: res = over_range ? '0 : (a >> amt);
            // Upper bits of b are whole turns, so only amt matters; amt = 0 makes a >> 8 vanish.
            OP_ROL: res = (a << amt) | (a >> (4'd8 - {1'b0, amt}));
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/ula_core.sv
// Registered 8-bit ALU: ten ops on R[a]/R[b], result plus zero/carry flags.
// Latency 1 cycle; no backpressure, a new result is captured every edge.
module ula_core
    import ula_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    ula_if.slave  bus
);

    opcode_t         op;
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    data_t           prod;
    data_t           shift_res;
    data_t           nxt_s;
    logic            nxt_carry;

    assign op   = opcode_t'(bus.select);
    assign sum  = {1'b0, bus.a} + {1'b0, bus.b};
    // Top bit of the 9-bit difference is set exactly when a < b.
    assign diff = {1'b0, bus.a} - {1'b0, bus.b};
    assign prod = bus.a * bus.b;

    ula_shifter u_shifter (
        .a   (bus.a),
        .b   (bus.b),
        .op  (op),
        .res (shift_res)
    );

    always_comb begin
        nxt_s     = '0;
        nxt_carry = 1'b0;
        case (op)
            OP_NOT: nxt_s = ~bus.a;
            OP_AND: nxt_s = bus.a & bus.b;
            OP_OR:  nxt_s = bus.a | bus.b;
            OP_XOR: nxt_s = bus.a ^ bus.b;
            OP_ADD: begin
                nxt_s     = sum[DATA_W-1:0];
                nxt_carry = sum[DATA_W];
            end
            OP_SUB: begin
                nxt_s     = diff[DATA_W-1:0];
                nxt_carry = diff[DATA_W];
            end
            OP_SLR, OP_SRR, OP_ROL: nxt_s = shift_res;
            OP_MUL: nxt_s = prod;
            default: begin
                nxt_s     = '0;
                nxt_carry = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s     <= '0;
            bus.zero  <= 1'b1;
            bus.carry <= 1'b0;
        end else begin
            bus.s     <= nxt_s;
            bus.zero  <= (nxt_s == '0);
            bus.carry <= nxt_carry;
        end
    end

endmodule

// File: tb/tb_ula_core.sv
// Scoreboarded bench for ula_core: expectations queued at drive time, checked after each edge.
module tb_ula_core;
    import ula_pkg::*;

    typedef struct {
        logic [7:0] s;
        logic       z;
        logic       c;
    } exp_t;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b1;
    int   tests  = 0;
    int   fails  = 0;
    exp_t q[$];

    ula_if bus ();

    ula_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 if (clk_en) clk = ~clk;

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        exp_t e;
        int   ai, bi, r, k;
        ai = int'(a);
        bi = int'(b);
        r  = 0;
        e.c = 1'b0;
        case (sel)
            4'd0: r = 255 - ai;
            4'd1: r = int'(a & b);
            4'd2: r = int'(a | b);
            4'd3: r = int'(a ^ b);
            4'd4: begin r = ai + bi; e.c = (r > 255); r = r % 256; end
            4'd5: begin e.c = (ai < bi); r = (ai - bi + 256) % 256; end
            4'd6: r = (bi >= 8) ? 0 : (ai * (2 ** bi)) % 256;
            4'd7: r = (bi >= 8) ? 0 : ai / (2 ** bi);
            4'd8: r = (ai * bi) % 256;
            4'd9: begin k = bi % 8; r = ((ai * (2 ** k)) + ai / (2 ** (8 - k))) % 256; end
            default: r = 0;
        endcase
        e.s = r[7:0];
        e.z = (r == 0);
        return e;
    endfunction

    // Drive one operation, queue its expectation, and move to 1 ns past the capturing edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        bus.a      = a;
        bus.b      = b;
        bus.select = sel;
        q.push_back(model(a, b, sel));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.a      = 8'hFF;
        bus.b      = 8'h01;
        bus.select = 4'd4;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.s !== 8'h00) begin fails++; $display("FAIL reset_s got=%b want=00000000", bus.s); end
        tests++; if (bus.zero !== 1'b1) begin fails++; $display("FAIL reset_zero got=%b want=1", bus.zero); end
        tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL reset_carry got=%b want=0", bus.carry); end
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (bus.s !== 8'h00) begin fails++; $display("FAIL reset_hold_s got=%b want=00000000", bus.s); end
        rst_n = 1'b1;
    endtask

    task automatic test_sweep();
        logic [7:0] want [10];
        exp_t e;
        want = '{8'b10111000, 8'b00000010, 8'b01000111, 8'b01000101, 8'b01001001,
                 8'b01000101, 8'b00011100, 8'b00010001, 8'b10001110, 8'b00011101};
        for (int i = 0; i < 10; i++) begin
            send(8'b01000111, 8'b00000010, 4'(i));
            e = q.pop_front();
            tests++; if (bus.s !== want[i]) begin fails++; $display("FAIL sweep_op%0d_s got=%b want=%b", i, bus.s, want[i]); end
            tests++; if (bus.zero !== e.z || bus.carry !== e.c) begin
                fails++; $display("FAIL sweep_op%0d_flags got z=%b c=%b want z=%b c=%b", i, bus.zero, bus.carry, e.z, e.c);
            end
        end
    endtask

    task automatic test_sub_zero();
        exp_t e;
        send(8'b01000111, 8'b01000111, 4'd5);
        e = q.pop_front();
        tests++; if (bus.s !== e.s || bus.s !== 8'h00) begin fails++; $display("FAIL sub_zero_s got=%b want=00000000", bus.s); end
        tests++; if (bus.zero !== 1'b1) begin fails++; $display("FAIL sub_zero_zero got=%b want=1", bus.zero); end
        tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL sub_zero_carry got=%b want=0", bus.carry); end
    endtask

    task automatic test_rol_wrap();
        exp_t e;
        send(8'b01000111, 8'd12, 4'd9);
        e = q.pop_front();
        tests++; if (bus.s !== 8'b01110100 || bus.s !== e.s) begin fails++; $display("FAIL rol_wrap_s got=%b want=01110100", bus.s); end
        send(8'b10000001, 8'd255, 4'd9);
        e = q.pop_front();
        tests++; if (bus.s !== 8'b11000000 || bus.s !== e.s) begin fails++; $display("FAIL rol_255_s got=%b want=11000000", bus.s); end
    endtask

    task automatic test_carry_limits();
        exp_t e;
        send(8'hFF, 8'h01, 4'd4);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h00 || bus.zero !== 1'b1 || bus.carry !== 1'b1) begin
            fails++; $display("FAIL add_ovf got s=%b z=%b c=%b want s=00000000 z=1 c=1", bus.s, bus.zero, bus.carry);
        end
        tests++; if (bus.carry !== e.c) begin fails++; $display("FAIL add_ovf_model got c=%b want c=%b", bus.carry, e.c); end
        send(8'h01, 8'h02, 4'd5);
        e = q.pop_front();
        tests++; if (bus.s !== 8'hFF || bus.carry !== 1'b1 || bus.zero !== 1'b0) begin
            fails++; $display("FAIL sub_borrow got s=%b z=%b c=%b want s=11111111 z=0 c=1", bus.s, bus.zero, bus.carry);
        end
        send(8'h47, 8'd8, 4'd6);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h00 || bus.zero !== 1'b1 || bus.s !== e.s) begin
            fails++; $display("FAIL slr_b8 got s=%b z=%b want s=00000000 z=1", bus.s, bus.zero);
        end
        send(8'h80, 8'd7, 4'd7);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h01 || bus.s !== e.s) begin fails++; $display("FAIL srr_b7 got=%b want=00000001", bus.s); end
        send(8'hFF, 8'hFF, 4'd8);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h01 || bus.carry !== 1'b0) begin
            fails++; $display("FAIL mul_ff got s=%b c=%b want s=00000001 c=0", bus.s, bus.carry);
        end
    endtask

    task automatic test_reserved();
        exp_t e;
        send(8'hFF, 8'hFF, 4'd12);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h00 || bus.zero !== 1'b1 || bus.carry !== 1'b0 || bus.s !== e.s) begin
            fails++; $display("FAIL reserved12 got s=%b z=%b c=%b want s=00000000 z=1 c=0", bus.s, bus.zero, bus.carry);
        end
        send(8'h47, 8'h02, 4'd15);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h00 || bus.zero !== 1'b1) begin
            fails++; $display("FAIL reserved15 got s=%b z=%b want s=00000000 z=1", bus.s, bus.zero);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        send(8'h10, 8'h20, 4'd4);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h30 || bus.s !== e.s) begin fails++; $display("FAIL mid_pre got=%b want=00110000", bus.s); end
        bus.a = 8'hFF;
        bus.b = 8'h01;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.s !== 8'h00 || bus.zero !== 1'b1 || bus.carry !== 1'b0) begin
            fails++; $display("FAIL mid_clear got s=%b z=%b c=%b want s=00000000 z=1 c=0", bus.s, bus.zero, bus.carry);
        end
        #1;
        rst_n = 1'b1;
        q.push_back(model(bus.a, bus.b, bus.select));
        @(posedge clk);
        #1;
        e = q.pop_front();
        tests++; if (bus.s !== 8'h00 || bus.zero !== 1'b1 || bus.carry !== 1'b1 || bus.carry !== e.c) begin
            fails++; $display("FAIL mid_release got s=%b z=%b c=%b want s=00000000 z=1 c=1", bus.s, bus.zero, bus.carry);
        end
        send(8'h47, 8'h02, 4'd4);
        e = q.pop_front();
        tests++; if (bus.s !== 8'h49 || bus.carry !== 1'b0) begin fails++; $display("FAIL mid_next got s=%b want s=01001001", bus.s); end
    endtask

    task automatic test_back_to_back();
        exp_t       e;
        logic [7:0] ra, rb;
        logic [3:0] rs;
        int         bad;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 3 == 0) ? 8'($urandom_range(0, 16)) : 8'($urandom_range(0, 255));
            rs = 4'($urandom_range(0, 15));
            send(ra, rb, rs);
            e = q.pop_front();
            tests++;
            if (bus.s !== e.s || bus.zero !== e.z || bus.carry !== e.c) begin
                fails++; bad++;
                if (bad <= 5)
                    $display("FAIL b2b a=%h b=%h op=%0d got s=%h z=%b c=%b want s=%h z=%b c=%b",
                             ra, rb, rs, bus.s, bus.zero, bus.carry, e.s, e.z, e.c);
            end
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL queue_drain got=%0d want=0", q.size()); end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_sub_zero();
        test_rol_wrap();
        test_carry_limits();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
